fft_loader: RTL and testbench

FFT_LOADER -- requirements
Module: fft_loader

---
 rtl/fft_loader_pkg.sv | 34 +++
 rtl/fft_loader_window_rom.sv | 52 +++++
 rtl/fft_loader.sv | 98 +++++++++
 tb/tb_fft_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_loader_pkg.sv
// Shared types, sizes and the complex-word packer for the FFT input loader.
package fft_loader_pkg;

  localparam int unsigned FFT_N      = 64;
  localparam int unsigned FFT_ADDR_W = 6;
  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned FFT_DATA_W = 2 * SAMPLE_W;
  localparam int unsigned DROP_W     = 8;

  typedef enum logic [2:0] {
    FILL,
    LAST,
    START,
    WAIT,
    CLEAR
  } state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] re;
    logic [SAMPLE_W-1:0] im;
  } cplx_t;

  // Pack real/imaginary halves into one FFT RAM word, real part on top.
  function automatic logic [FFT_DATA_W-1:0] pack_complex(
    input logic [SAMPLE_W-1:0] re,
    input logic [SAMPLE_W-1:0] im
  );
    cplx_t word;
    word.re = re;
    word.im = im;
    return word;
  endfunction

endpackage

// File: rtl/fft_loader_window_rom.sv
// 64-point Hann window, unsigned Q1.15: round(32767*0.5*(1-cos(2*pi*i/63))).
module window_rom
  import fft_loader_pkg::*;
(
  input  logic [FFT_ADDR_W-1:0] index,
  output logic [SAMPLE_W-1:0]   coef
);

  logic [FFT_ADDR_W-2:0] half;

  // Table is symmetric (w[i] == w[63-i]), so only the first half is stored.
  always_comb begin
    half = index[FFT_ADDR_W-1] ? ~index[FFT_ADDR_W-2:0] : index[FFT_ADDR_W-2:0];
    coef = '0;
    case (half)
      5'd0:  coef = 16'd0;
      5'd1:  coef = 16'd81;
      5'd2:  coef = 16'd325;
      5'd3:  coef = 16'd728;
      5'd4:  coef = 16'd1286;
      5'd5:  coef = 16'd1995;
      5'd6:  coef = 16'd2847;
      5'd7:  coef = 16'd3833;
      5'd8:  coef = 16'd4944;
      5'd9:  coef = 16'd6169;
      5'd10: coef = 16'd7495;
      5'd11: coef = 16'd8909;
      5'd12: coef = 16'd10398;
      5'd13: coef = 16'd11946;
      5'd14: coef = 16'd13539;
      5'd15: coef = 16'd15159;
      5'd16: coef = 16'd16792;
      5'd17: coef = 16'd18421;
      5'd18: coef = 16'd20029;
      5'd19: coef = 16'd21601;
      5'd20: coef = 16'd23122;
      5'd21: coef = 16'd24575;
      5'd22: coef = 16'd25947;
      5'd23: coef = 16'd27224;
      5'd24: coef = 16'd28393;
      5'd25: coef = 16'd29443;
      5'd26: coef = 16'd30363;
      5'd27: coef = 16'd31145;
      5'd28: coef = 16'd31779;
      5'd29: coef = 16'd32260;
      5'd30: coef = 16'd32584;
      5'd31: coef = 16'd32747;
      default: coef = '0;
    endcase
  end

endmodule

// File: rtl/fft_loader.sv
// Collects 64 audio samples (optionally Hann-windowed) into the FFT input RAM,
// kicks the FFT, and waits for the consumer before starting the next frame.
module fft_loader
  import fft_loader_pkg::*;
#(
  parameter bit WINDOW_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [SAMPLE_W-1:0]   sample_data,
  output logic                  sample_ready,
  input  logic                  fft_done,
  input  logic                  frame_release,
  output logic                  fft_load,
  output logic [FFT_ADDR_W-1:0] fft_load_address,
  output logic [FFT_DATA_W-1:0] fft_data,
  output logic                  fft_start,
  output logic                  fft_clear,
  output logic [DROP_W-1:0]     drop_count
);

  localparam logic [FFT_ADDR_W-1:0] LAST_INDEX = FFT_ADDR_W'(FFT_N - 1);

  state_t                   state;
  state_t                   next_state;
  logic [FFT_ADDR_W-1:0]    index;
  logic [SAMPLE_W-1:0]      coef;
  logic signed [FFT_DATA_W-1:0] product;
  logic [SAMPLE_W-1:0]      real_part;
  logic                     accept;

  assign accept = sample_valid & sample_ready;

  window_rom u_window_rom (
    .index (index),
    .coef  (coef)
  );

  // Q1.15 x Q1.15 multiply; bits [30:15] of the product, truncated toward -inf.
  always_comb begin
    product   = FFT_DATA_W'($signed(sample_data)) * FFT_DATA_W'($signed(coef));
    real_part = WINDOW_EN ? SAMPLE_W'(product >>> (SAMPLE_W - 1)) : sample_data;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      FILL:    if (accept && (index == LAST_INDEX)) next_state = LAST;
      LAST:    next_state = START;
      START:   next_state = WAIT;
      WAIT:    if (fft_done && frame_release) next_state = CLEAR;
      CLEAR:   next_state = FILL;
      default: next_state = FILL;
    endcase
  end

  // Registered outputs, sample index and drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      index            <= '0;
      sample_ready     <= 1'b1;
      fft_load         <= 1'b0;
      fft_load_address <= '0;
      fft_data         <= '0;
      fft_start        <= 1'b0;
      fft_clear        <= 1'b0;
      drop_count       <= '0;
    end else begin
      sample_ready <= (next_state == FILL);
      fft_load     <= accept;
      fft_start    <= (next_state == START);
      fft_clear    <= (next_state == CLEAR);
      if (accept) begin
        fft_load_address <= index;
        fft_data         <= pack_complex(real_part, '0);
        index            <= index + 6'd1;
      end
      if (state == CLEAR) begin
        index <= '0;
      end
      if (sample_valid && !sample_ready && (drop_count != '1)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft_loader.sv
// Directed bench for fft_loader: one pass-through and one windowed instance share stimulus.
module tb_fft_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        fft_done;
  logic        frame_release;

  logic        ready0, load0, start0, clear0;
  logic [5:0]  addr0;
  logic [31:0] data0;
  logic [7:0]  drop0;
  logic        ready1, load1, start1, clear1;
  logic [5:0]  addr1;
  logic [31:0] data1;
  logic [7:0]  drop1;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fft_loader #(.WINDOW_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_ready(ready0), .fft_done(fft_done), .frame_release(frame_release),
    .fft_load(load0), .fft_load_address(addr0), .fft_data(data0),
    .fft_start(start0), .fft_clear(clear0), .drop_count(drop0)
  );

  fft_loader #(.WINDOW_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_ready(ready1), .fft_done(fft_done), .frame_release(frame_release),
    .fft_load(load1), .fft_load_address(addr1), .fft_data(data1),
    .fft_start(start1), .fft_clear(clear1), .drop_count(drop1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: consumer finishes, loader clears and returns to FILL.
  task automatic release_frame();
    fft_done = 1'b1; frame_release = 1'b1;
    step();
    fft_done = 1'b0; frame_release = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [47:0] got;
    reset = 1'b1; sample_valid = 1'b0; sample_data = '0; fft_done = 1'b0; frame_release = 1'b0;
    step(); step();
    got = {load0, addr0, data0, start0, clear0, drop0};
    checks++; if (got !== '0) $display("FAIL reset_outputs0: got %h want 0", got); else passes++;
    got = {load1, addr1, data1, start1, clear1, drop1};
    checks++; if (got !== '0) $display("FAIL reset_outputs1: got %h want 0", got); else passes++;
    checks++; if ({ready0, ready1} !== 2'b11) $display("FAIL reset_ready: got %b want 11", {ready0, ready1}); else passes++;
    reset = 1'b0;
    step();
    checks++; if ({ready0, load0} !== 2'b10) $display("FAIL idle_after_reset: got %b want 10", {ready0, load0}); else passes++;
  endtask

  task automatic test_fill_passthrough();
    logic [40:0] got, exp;
    int n;
    for (int i = 0; i < 64; i++) begin
      sample_valid = 1'b1; sample_data = 16'(i * 16);
      step();
      got = {ready0, start0, load0, addr0, data0};
      exp = {(i != 63), 1'b0, 1'b1, 6'(i), 16'(i * 16), 16'h0000};
      checks++; if (got !== exp) $display("FAIL fill_write_%0d: got %h want %h", i, got, exp); else passes++;
    end
    sample_valid = 1'b0;
    step();
    checks++; if ({start0, load0, ready0} !== 3'b100) $display("FAIL start_pulse: got %b want 100", {start0, load0, ready0}); else passes++;
    n = 0;
    repeat (5) begin step(); if (start0) n++; end
    checks++; if (n !== 0) $display("FAIL single_start: got %0d extra want 0", n); else passes++;
  endtask

  task automatic test_drop_saturate();
    int loads;
    loads = 0;
    sample_valid = 1'b1; sample_data = 16'h5555;
    for (int c = 1; c <= 300; c++) begin
      step();
      if (load0 || load1) loads++;
      if (c == 10) begin
        checks++; if (drop0 !== 8'd10) $display("FAIL drop_count_10: got %0d want 10", drop0); else passes++;
      end
    end
    sample_valid = 1'b0;
    checks++; if (drop0 !== 8'd255) $display("FAIL drop_saturate0: got %0d want 255", drop0); else passes++;
    checks++; if (drop1 !== 8'd255) $display("FAIL drop_saturate1: got %0d want 255", drop1); else passes++;
    checks++; if (loads !== 0) $display("FAIL drop_no_load: got %0d want 0", loads); else passes++;
  endtask

  task automatic test_release();
    int n;
    n = 0;
    fft_done = 1'b0; frame_release = 1'b1;
    repeat (5) begin step(); if (clear0 || ready0) n++; end
    checks++; if (n !== 0) $display("FAIL release_without_done: got %0d want 0", n); else passes++;
    frame_release = 1'b0; fft_done = 1'b1;
    repeat (10) begin step(); if (clear0 || ready0) n++; end
    checks++; if (n !== 0) $display("FAIL done_without_release: got %0d want 0", n); else passes++;
    frame_release = 1'b1;
    step();
    checks++; if ({clear0, ready0} !== 2'b10) $display("FAIL clear_pulse: got %b want 10", {clear0, ready0}); else passes++;
    fft_done = 1'b0; frame_release = 1'b0;
    step();
    checks++; if ({clear0, ready0} !== 2'b01) $display("FAIL clear_to_fill: got %b want 01", {clear0, ready0}); else passes++;
  endtask

  task automatic test_windowed();
    logic [15:0] exp;
    bit          chk;
    int          imag_bad;
    imag_bad = 0;
    for (int i = 0; i < 64; i++) begin
      case (i)
        5:       sample_data = 16'hFFFF;
        10:      sample_data = 16'h4000;
        21:      sample_data = 16'h8000;
        default: sample_data = 16'h7FFF;
      endcase
      sample_valid = 1'b1;
      step();
      if (load1 !== 1'b1 || addr1 !== 6'(i) || data1[15:0] !== 16'h0000) imag_bad++;
      chk = 1'b1;
      case (i)
        0:       exp = 16'h0000;
        1:       exp = 16'h0050;
        5:       exp = 16'hFFFF;
        10:      exp = 16'h0EA3;
        21:      exp = 16'hA001;
        31:      exp = 16'h7FEA;
        32:      exp = 16'h7FEA;
        63:      exp = 16'h0000;
        default: begin exp = 16'h0000; chk = 1'b0; end
      endcase
      if (chk) begin
        checks++; if (data1[31:16] !== exp) $display("FAIL window_real_%0d: got %h want %h", i, data1[31:16], exp); else passes++;
      end
      if (i == 10 || i == 21) begin
        checks++; if (data0[31:16] !== sample_data) $display("FAIL passthrough_real_%0d: got %h want %h", i, data0[31:16], sample_data); else passes++;
      end
    end
    sample_valid = 1'b0;
    checks++; if (imag_bad !== 0) $display("FAIL window_imag_zero: got %0d bad writes want 0", imag_bad); else passes++;
    step(); step();
  endtask

  task automatic test_toggle();
    logic [38:0] exp;
    int starts;
    for (int c = 0; c < 128; c++) begin
      sample_valid = (c % 2 == 0);
      sample_data  = 16'h0100 + 16'(c / 2);
      step();
      if (c % 2 == 0) begin
        exp = {1'b1, 6'(c / 2), 16'h0100 + 16'(c / 2), 16'h0000};
        checks++; if ({load0, addr0, data0} !== exp) $display("FAIL toggle_write_%0d: got %h want %h", c / 2, {load0, addr0, data0}, exp); else passes++;
      end else begin
        checks++; if (load0 !== 1'b0) $display("FAIL toggle_idle_%0d: got %b want 0", c, load0); else passes++;
      end
    end
    sample_valid = 1'b0;
    starts = start0 ? 1 : 0;
    repeat (4) begin step(); if (start0) starts++; end
    checks++; if (starts !== 1) $display("FAIL toggle_start_count: got %0d want 1", starts); else passes++;
  endtask

  task automatic test_reset_midfill();
    logic [47:0] got;
    for (int i = 0; i < 20; i++) begin
      sample_valid = 1'b1; sample_data = 16'h1234;
      step();
    end
    reset = 1'b1;
    step();
    got = {load0, addr0, data0, start0, clear0, drop0};
    checks++; if (got !== '0) $display("FAIL midfill_reset_outputs: got %h want 0", got); else passes++;
    checks++; if (ready0 !== 1'b1) $display("FAIL midfill_reset_ready: got %b want 1", ready0); else passes++;
    reset = 1'b0; sample_data = 16'h0AAA;
    step();
    checks++; if ({load0, addr0, data0} !== {1'b1, 6'd0, 16'h0AAA, 16'h0000}) $display("FAIL midfill_restart_addr: got %h want %h", {load0, addr0, data0}, {1'b1, 6'd0, 16'h0AAA, 16'h0000}); else passes++;
    checks++; if (drop0 !== 8'd0) $display("FAIL midfill_drop_zero: got %0d want 0", drop0); else passes++;
  endtask

  task automatic test_reset_in_wait();
    for (int i = 1; i < 64; i++) begin
      sample_valid = 1'b1; sample_data = 16'h0000;
      step();
    end
    sample_valid = 1'b0;
    step(); step();
    checks++; if (ready0 !== 1'b0) $display("FAIL wait_not_ready: got %b want 0", ready0); else passes++;
    fft_done = 1'b1; frame_release = 1'b1; reset = 1'b1;
    step();
    checks++; if ({clear0, ready0} !== 2'b01) $display("FAIL reset_beats_release: got %b want 01", {clear0, ready0}); else passes++;
    reset = 1'b0; fft_done = 1'b0; frame_release = 1'b0;
    sample_valid = 1'b1; sample_data = 16'h0777;
    step();
    checks++; if ({load0, addr0, data0} !== {1'b1, 6'd0, 16'h0777, 16'h0000}) $display("FAIL wait_reset_restart: got %h want %h", {load0, addr0, data0}, {1'b1, 6'd0, 16'h0777, 16'h0000}); else passes++;
    sample_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fill_passthrough();
    test_drop_saturate();
    test_release();
    test_windowed();
    release_frame();
    test_toggle();
    release_frame();
    test_reset_midfill();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
